dm_sba_axil_bridge: RTL and testbench
=====================================

// Module: dm_sba_axil_bridge
// PURPOSE
// Downstream of the debug module's system-bus-access master port (req/gnt/r_valid).
// Converts each single-beat SBA request into one AXI4-Lite read or write transaction
// and returns the data or write acknowledgement as a one-cycle r_valid pulse.
// Allows exactly one outstanding transaction, which serialises debugger memory accesses.
// PARAMETERS
// BusWidth   32  SBA/AXI-Lite address and data width (32 or 64)
// PORTS
// clk_i            in   1            clock
// rst_i            in   1            asynchronous reset, active-high
// slv_req_i        in   1            SBA request, held until slv_gnt_o
// slv_we_i         in   1            1 = write, 0 = read
// slv_addr_i       in   BusWidth     byte address
// slv_wdata_i      in   BusWidth     write data
// slv_be_i         in   BusWidth/8   byte enables
// slv_gnt_o        out  1            request accepted (1-cycle pulse)
// slv_r_valid_o    out  1            response (read data or write ack), 1-cycle pulse
// slv_r_rdata_o    out  BusWidth     read data, valid with slv_r_valid_o
// slv_err_o        out  1            AXI resp != OKAY, valid with slv_r_valid_o
// m_aw_valid_o / m_aw_ready_i / m_aw_addr_o[BusWidth] / m_aw_prot_o[3]   AXI-Lite AW
// m_w_valid_o / m_w_ready_i / m_w_data_o[BusWidth] / m_w_strb_o[BusWidth/8]  AXI-Lite W
// m_b_valid_i / m_b_ready_o / m_b_resp_i[2]                             AXI-Lite B
// m_ar_valid_o / m_ar_ready_i / m_ar_addr_o[BusWidth] / m_ar_prot_o[3]   AXI-Lite AR
// m_r_valid_i / m_r_ready_o / m_r_data_i[BusWidth] / m_r_resp_i[2]       AXI-Lite R
// BEHAVIOUR
// - Reset: state IDLE; every valid/ready/gnt/r_valid/err output 0; rdata 0; addr/data regs 0.
// - *_prot_o fixed at 3'b000. Addresses are forwarded unaligned; strb = be.
// - FSM IDLE: on slv_req_i, register addr/wdata/be/we (no gnt yet); we=1 -> WRITE, we=0 -> READ.
// - WRITE: aw_valid and w_valid both asserted from the first cycle; each drops after its own
//   handshake (aw_done/w_done flags); the two may complete in either order or in the same cycle.
//   When both are done: slv_gnt_o pulses for 1 cycle; go to WRESP.
// - WRESP: m_b_ready_o=1. On b_valid: r_valid pulses next cycle; err=(b_resp!=0); rdata unchanged; -> IDLE.
// - READ: ar_valid=1 until ar_ready; on handshake slv_gnt_o pulses for 1 cycle; -> RRESP.
// - RRESP: m_r_ready_o=1. On r_valid: register r_data/resp; r_valid pulses next cycle; -> IDLE.
// - Valid signals never drop before their handshake; request payload is stable while valid is high.
// - Latency: gnt >= 2 cycles after req (1 capture cycle + 1 handshake cycle);
//   r_valid is exactly 1 cycle after the B/R handshake.
// - A new request is accepted in IDLE only, at the earliest in the cycle after r_valid.
//   While not IDLE, slv_req_i is ignored.
// - B/R beats arriving outside WRESP/RRESP are not accepted (ready=0).
// - Reset mid-transaction aborts immediately to IDLE with outputs at their reset values;
//   integration guarantees that the AXI slave is reset together with this block.
// - slv_err_o is 0 whenever slv_r_valid_o is 0.
// TESTING
// - Read, ar_ready=1, r after 3 cycles: addr 0x8000_0010 -> gnt 2 cycles after req, r_valid
//   with rdata 0xDEAD_BEEF, err=0.
// - Write: aw_ready 3 cycles late, w_ready immediate -> gnt only after the AW handshake; B OKAY
//   -> r_valid 1 cycle later, err=0; strb equals be=4'b0011.
// - Write with W accepted before AW, and with both in the same cycle -> exactly one gnt and one
//   r_valid each.
// - Read returning RRESP=SLVERR (2'b10) -> r_valid with err=1; next OKAY read -> err=0.
// - Back-to-back reads with req held high -> second capture only in the cycle after the first r_valid.
// - Assert rst_i while in WRESP -> all outputs 0 in the same cycle; a subsequent read completes normally.

Source files
------------

// File: rtl/dm_sba_axil_bridge_if.sv
// -----------------------------------------------------------------------------
// dm_sba_axil_bridge_if
// Bundles the debug-module SBA request/response signals and the AXI4-Lite
// master channels that dm_sba_axil_bridge sits between. Signal names keep the
// bridge's point of view (_i = into the bridge, _o = out of the bridge).
//
// Modports
//   master : the bridge itself (SBA slave side, AXI-Lite master side)
//   slave  : the environment (SBA requester plus AXI-Lite slave)
//
// Signals
//   slv_req_i/we_i/addr_i/wdata_i/be_i     SBA request
//   slv_gnt_o/r_valid_o/r_rdata_o/err_o    SBA grant and response
//   m_aw_*, m_w_*, m_b_*, m_ar_*, m_r_*    AXI4-Lite channels
// -----------------------------------------------------------------------------
interface dm_sba_axil_bridge_if #(
    parameter int BusWidth = 32
);
    logic                    slv_req_i;
    logic                    slv_we_i;
    logic [BusWidth-1:0]     slv_addr_i;
    logic [BusWidth-1:0]     slv_wdata_i;
    logic [BusWidth/8-1:0]   slv_be_i;
    logic                    slv_gnt_o;
    logic                    slv_r_valid_o;
    logic [BusWidth-1:0]     slv_r_rdata_o;
    logic                    slv_err_o;

    logic                    m_aw_valid_o;
    logic                    m_aw_ready_i;
    logic [BusWidth-1:0]     m_aw_addr_o;
    logic [2:0]              m_aw_prot_o;
    logic                    m_w_valid_o;
    logic                    m_w_ready_i;
    logic [BusWidth-1:0]     m_w_data_o;
    logic [BusWidth/8-1:0]   m_w_strb_o;
    logic                    m_b_valid_i;
    logic                    m_b_ready_o;
    logic [1:0]              m_b_resp_i;
    logic                    m_ar_valid_o;
    logic                    m_ar_ready_i;
    logic [BusWidth-1:0]     m_ar_addr_o;
    logic [2:0]              m_ar_prot_o;
    logic                    m_r_valid_i;
    logic                    m_r_ready_o;
    logic [BusWidth-1:0]     m_r_data_i;
    logic [1:0]              m_r_resp_i;

    modport master (
        input  slv_req_i, slv_we_i, slv_addr_i, slv_wdata_i, slv_be_i,
        output slv_gnt_o, slv_r_valid_o, slv_r_rdata_o, slv_err_o,
        output m_aw_valid_o, m_aw_addr_o, m_aw_prot_o,
        input  m_aw_ready_i,
        output m_w_valid_o, m_w_data_o, m_w_strb_o,
        input  m_w_ready_i,
        input  m_b_valid_i, m_b_resp_i,
        output m_b_ready_o,
        output m_ar_valid_o, m_ar_addr_o, m_ar_prot_o,
        input  m_ar_ready_i,
        input  m_r_valid_i, m_r_data_i, m_r_resp_i,
        output m_r_ready_o
    );

    modport slave (
        output slv_req_i, slv_we_i, slv_addr_i, slv_wdata_i, slv_be_i,
        input  slv_gnt_o, slv_r_valid_o, slv_r_rdata_o, slv_err_o,
        input  m_aw_valid_o, m_aw_addr_o, m_aw_prot_o,
        output m_aw_ready_i,
        input  m_w_valid_o, m_w_data_o, m_w_strb_o,
        output m_w_ready_i,
        output m_b_valid_i, m_b_resp_i,
        input  m_b_ready_o,
        input  m_ar_valid_o, m_ar_addr_o, m_ar_prot_o,
        output m_ar_ready_i,
        output m_r_valid_i, m_r_data_i, m_r_resp_i,
        input  m_r_ready_o
    );
endinterface

// File: rtl/dm_sba_axil_bridge.sv
// -----------------------------------------------------------------------------
// dm_sba_axil_bridge
// Turns each single-beat debug-module SBA request into one AXI4-Lite read or
// write and returns read data / write ack as a one-cycle r_valid pulse. Only
// one transaction is ever outstanding.
//
// Ports
//   clk_i  : clock
//   rst_i  : asynchronous reset, active-high
//   bus    : dm_sba_axil_bridge_if.master (SBA request/response + AXI-Lite)
// -----------------------------------------------------------------------------
module dm_sba_axil_bridge #(
    parameter int BusWidth = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    dm_sba_axil_bridge_if.master  bus
);
    localparam int StrbWidth = BusWidth / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_READ,
        S_RRESP
    } state_t;

    state_t                r_state;
    logic [BusWidth-1:0]   r_addr;
    logic [BusWidth-1:0]   r_wdata;
    logic [StrbWidth-1:0]  r_be;
    logic                  r_aw_valid;
    logic                  r_w_valid;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic                  r_b_ready;
    logic                  r_ar_valid;
    logic                  r_r_ready;
    logic                  r_gnt;
    logic                  r_r_valid;
    logic [BusWidth-1:0]   r_rdata;
    logic                  r_err;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_fin;
    logic w_w_fin;

    assign w_aw_hs  = r_aw_valid & bus.m_aw_ready_i;
    assign w_w_hs   = r_w_valid  & bus.m_w_ready_i;
    // A channel counts as finished if it completed earlier or completes now,
    // so AW and W may finish in either order or in the same cycle.
    assign w_aw_fin = r_aw_done | w_aw_hs;
    assign w_w_fin  = r_w_done  | w_w_hs;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_b_ready  <= 1'b0;
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b0;
            r_gnt      <= 1'b0;
            r_r_valid  <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            // gnt, r_valid and err are single-cycle pulses
            r_gnt     <= 1'b0;
            r_r_valid <= 1'b0;
            r_err     <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    // Holding off while r_valid is high keeps a held-high req
                    // from being captured before the requester saw the response.
                    if (bus.slv_req_i && !r_r_valid) begin
                        r_addr  <= bus.slv_addr_i;
                        r_wdata <= bus.slv_wdata_i;
                        r_be    <= bus.slv_be_i;
                        if (bus.slv_we_i) begin
                            r_state    <= S_WRITE;
                            r_aw_valid <= 1'b1;
                            r_w_valid  <= 1'b1;
                            r_aw_done  <= 1'b0;
                            r_w_done   <= 1'b0;
                        end else begin
                            r_state    <= S_READ;
                            r_ar_valid <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_aw_hs) begin
                        r_aw_valid <= 1'b0;
                        r_aw_done  <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_valid <= 1'b0;
                        r_w_done  <= 1'b1;
                    end
                    if (w_aw_fin && w_w_fin) begin
                        r_gnt     <= 1'b1;
                        r_b_ready <= 1'b1;
                        r_state   <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (bus.m_b_valid_i) begin
                        r_b_ready <= 1'b0;
                        r_r_valid <= 1'b1;
                        r_err     <= |bus.m_b_resp_i;
                        r_state   <= S_IDLE;
                    end
                end
                S_READ: begin
                    if (bus.m_ar_ready_i) begin
                        r_ar_valid <= 1'b0;
                        r_gnt      <= 1'b1;
                        r_r_ready  <= 1'b1;
                        r_state    <= S_RRESP;
                    end
                end
                S_RRESP: begin
                    if (bus.m_r_valid_i) begin
                        r_r_ready <= 1'b0;
                        r_r_valid <= 1'b1;
                        r_rdata   <= bus.m_r_data_i;
                        r_err     <= |bus.m_r_resp_i;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.slv_gnt_o     = r_gnt;
    assign bus.slv_r_valid_o = r_r_valid;
    assign bus.slv_r_rdata_o = r_rdata;
    assign bus.slv_err_o     = r_err;

    assign bus.m_aw_valid_o  = r_aw_valid;
    assign bus.m_aw_addr_o   = r_addr;
    assign bus.m_aw_prot_o   = 3'b000;
    assign bus.m_w_valid_o   = r_w_valid;
    assign bus.m_w_data_o    = r_wdata;
    assign bus.m_w_strb_o    = r_be;
    assign bus.m_b_ready_o   = r_b_ready;
    assign bus.m_ar_valid_o  = r_ar_valid;
    assign bus.m_ar_addr_o   = r_addr;
    assign bus.m_ar_prot_o   = 3'b000;
    assign bus.m_r_ready_o   = r_r_ready;
endmodule

// File: tb/tb_dm_sba_axil_bridge.sv
module tb_dm_sba_axil_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    dm_sba_axil_bridge_if #(.BusWidth(32)) bus ();

    dm_sba_axil_bridge #(.BusWidth(32)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // One SBA transaction plus how the AXI slave behaves and what must come back.
    // d_a: AW/AR ready delay, d_w: W ready delay, d_rsp: B/R delay after handshake.
    // exp_gnt / exp_rv: cycle index (req driven in cycle 0) of gnt and r_valid.
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          d_a;
        int          d_w;
        int          d_rsp;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          exp_gnt;
        int          exp_rv;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.slv_req_i    = 1'b0;
        bus.slv_we_i     = 1'b0;
        bus.slv_addr_i   = '0;
        bus.slv_wdata_i  = '0;
        bus.slv_be_i     = '0;
        bus.m_aw_ready_i = 1'b0;
        bus.m_w_ready_i  = 1'b0;
        bus.m_b_valid_i  = 1'b0;
        bus.m_b_resp_i   = '0;
        bus.m_ar_ready_i = 1'b0;
        bus.m_r_valid_i  = 1'b0;
        bus.m_r_data_i   = '0;
        bus.m_r_resp_i   = '0;
    endtask

    task automatic chk_all_idle(input string nm);
        chk({nm, " gnt"},      32'(bus.slv_gnt_o), 32'd0);
        chk({nm, " r_valid"},  32'(bus.slv_r_valid_o), 32'd0);
        chk({nm, " err"},      32'(bus.slv_err_o), 32'd0);
        chk({nm, " rdata"},    bus.slv_r_rdata_o, 32'd0);
        chk({nm, " aw_valid"}, 32'(bus.m_aw_valid_o), 32'd0);
        chk({nm, " w_valid"},  32'(bus.m_w_valid_o), 32'd0);
        chk({nm, " ar_valid"}, 32'(bus.m_ar_valid_o), 32'd0);
        chk({nm, " b_ready"},  32'(bus.m_b_ready_o), 32'd0);
        chk({nm, " r_ready"},  32'(bus.m_r_ready_o), 32'd0);
        chk({nm, " aw_addr"},  bus.m_aw_addr_o, 32'd0);
        chk({nm, " w_data"},   bus.m_w_data_o, 32'd0);
        chk({nm, " strb"},     32'(bus.m_w_strb_o), 32'd0);
    endtask

    // Called at #1 after a clock edge; that cycle is cycle 0 of the transaction.
    task automatic do_txn(input vec_t v, input string nm);
        int gnt_t = -1, rv_t = -1, gnt_n = 0, rv_n = 0;
        int a_hs = -1, w_hs = -1, a_seen = 0, w_seen = 0, last;
        bit rsp_done = 1'b0, leak = 1'b0, stray = 1'b0, pay_ok = 1'b1;
        logic [31:0] got_rdata = '0;
        logic        got_err = 1'b0;
        bus.slv_we_i    = v.we;
        bus.slv_addr_i  = v.addr;
        bus.slv_wdata_i = v.wdata;
        bus.slv_be_i    = v.be;
        bus.slv_req_i   = 1'b1;
        for (int t = 0; t < 60; t++) begin
            if (t > 0) step();
            if (bus.slv_gnt_o) begin
                gnt_n++;
                if (gnt_t < 0) gnt_t = t;
            end
            if (bus.slv_r_valid_o) begin
                rv_n++;
                if (rv_t < 0) begin
                    rv_t      = t;
                    got_rdata = bus.slv_r_rdata_o;
                    got_err   = bus.slv_err_o;
                end
            end else if (bus.slv_err_o) begin
                leak = 1'b1;
            end
            if (v.we ? bus.m_r_ready_o : bus.m_b_ready_o) stray = 1'b1;
            if (gnt_t >= 0 && t > gnt_t) bus.slv_req_i = 1'b0;
            if (v.we) begin
                bus.m_aw_ready_i = bus.m_aw_valid_o && (a_seen >= v.d_a);
                if (bus.m_aw_valid_o) begin
                    if (bus.m_aw_ready_i) begin
                        a_hs = t;
                        if (bus.m_aw_addr_o !== v.addr || bus.m_aw_prot_o !== 3'b000) pay_ok = 1'b0;
                    end
                    a_seen++;
                end
                bus.m_w_ready_i = bus.m_w_valid_o && (w_seen >= v.d_w);
                if (bus.m_w_valid_o) begin
                    if (bus.m_w_ready_i) begin
                        w_hs = t;
                        if (bus.m_w_data_o !== v.wdata || bus.m_w_strb_o !== v.be) pay_ok = 1'b0;
                    end
                    w_seen++;
                end
                last = (a_hs > w_hs) ? a_hs : w_hs;
                bus.m_b_valid_i = (a_hs >= 0) && (w_hs >= 0) && !rsp_done && (t >= last + 1 + v.d_rsp);
                bus.m_b_resp_i  = v.resp;
                if (bus.m_b_valid_i && bus.m_b_ready_o) rsp_done = 1'b1;
            end else begin
                bus.m_ar_ready_i = bus.m_ar_valid_o && (a_seen >= v.d_a);
                if (bus.m_ar_valid_o) begin
                    if (bus.m_ar_ready_i) begin
                        a_hs = t;
                        if (bus.m_ar_addr_o !== v.addr || bus.m_ar_prot_o !== 3'b000) pay_ok = 1'b0;
                    end
                    a_seen++;
                end
                bus.m_r_valid_i = (a_hs >= 0) && !rsp_done && (t >= a_hs + 1 + v.d_rsp);
                bus.m_r_data_i  = v.rdata;
                bus.m_r_resp_i  = v.resp;
                if (bus.m_r_valid_i && bus.m_r_ready_o) rsp_done = 1'b1;
            end
            if (rv_t >= 0 && t >= rv_t + 2) break;
        end
        idle_inputs();
        chk_int({nm, " gnt_cycle"}, gnt_t, v.exp_gnt);
        chk_int({nm, " gnt_count"}, gnt_n, 1);
        chk_int({nm, " rvalid_cycle"}, rv_t, v.exp_rv);
        chk_int({nm, " rvalid_count"}, rv_n, 1);
        chk({nm, " rdata"}, got_rdata, v.exp_rdata);
        chk({nm, " err"}, 32'(got_err), 32'(v.exp_err));
        chk({nm, " err_without_rvalid"}, 32'(leak), 32'd0);
        chk({nm, " wrong_resp_ready"}, 32'(stray), 32'd0);
        chk_int({nm, " payload"}, (pay_ok && a_hs >= 0 && (!v.we || w_hs >= 0)) ? 1 : 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t post;
        //           we  addr           wdata          be     da dw dr rdata          resp   gnt rv exp_rdata      err
        vecs[0] = '{1'b0, 32'h8000_0010, 32'h0,         4'hF,  0, 0, 3, 32'hDEAD_BEEF, 2'b00, 2, 6, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b1, 32'h1000_0004, 32'h1234_5678, 4'h3,  3, 0, 0, 32'h0,         2'b00, 5, 6, 32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b1, 32'h2000_0003, 32'hA5A5_5A5A, 4'hF,  2, 0, 1, 32'h0,         2'b00, 4, 6, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{1'b1, 32'h3000_0008, 32'h0F0F_F0F0, 4'hC,  1, 1, 2, 32'h0,         2'b00, 3, 6, 32'hDEAD_BEEF, 1'b0};
        vecs[4] = '{1'b1, 32'h3000_000C, 32'h1357_9BDF, 4'h1,  0, 2, 0, 32'h0,         2'b11, 4, 5, 32'hDEAD_BEEF, 1'b1};
        vecs[5] = '{1'b0, 32'h4000_0020, 32'h0,         4'hF,  1, 0, 0, 32'h0BAD_F00D, 2'b10, 3, 4, 32'h0BAD_F00D, 1'b1};
        vecs[6] = '{1'b0, 32'h4000_0024, 32'h0,         4'hF,  0, 0, 0, 32'h1111_2222, 2'b00, 2, 3, 32'h1111_2222, 1'b0};

        idle_inputs();
        rst = 1'b1;
        step();
        step();
        chk_all_idle("reset");
        #2 rst = 1'b0;
        step();
        chk_all_idle("after_reset");

        foreach (vecs[i]) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
            step();
        end

        // Back-to-back reads with req held high; R beat offered before RRESP.
        bus.slv_we_i     = 1'b0;
        bus.slv_addr_i   = 32'h5000_0000;
        bus.slv_req_i    = 1'b1;
        bus.m_ar_ready_i = 1'b1;
        bus.m_r_valid_i  = 1'b1;
        bus.m_r_data_i   = 32'hCAFE_0001;
        step();
        chk("b2b t1 r_ready_outside_rresp", 32'(bus.m_r_ready_o), 32'd0);
        chk("b2b t1 ar_valid", 32'(bus.m_ar_valid_o), 32'd1);
        step();
        chk("b2b t2 gnt", 32'(bus.slv_gnt_o), 32'd1);
        chk("b2b t2 r_ready", 32'(bus.m_r_ready_o), 32'd1);
        step();
        chk("b2b t3 r_valid", 32'(bus.slv_r_valid_o), 32'd1);
        chk("b2b t3 rdata", bus.slv_r_rdata_o, 32'hCAFE_0001);
        chk("b2b t3 ar_valid", 32'(bus.m_ar_valid_o), 32'd0);
        bus.m_r_data_i = 32'hCAFE_0002;
        step();
        chk("b2b t4 no_early_capture", 32'(bus.m_ar_valid_o), 32'd0);
        chk("b2b t4 r_valid", 32'(bus.slv_r_valid_o), 32'd0);
        step();
        chk("b2b t5 second_capture", 32'(bus.m_ar_valid_o), 32'd1);
        step();
        chk("b2b t6 gnt", 32'(bus.slv_gnt_o), 32'd1);
        bus.slv_req_i = 1'b0;
        step();
        chk("b2b t7 r_valid", 32'(bus.slv_r_valid_o), 32'd1);
        chk("b2b t7 rdata", bus.slv_r_rdata_o, 32'hCAFE_0002);
        idle_inputs();
        step();
        chk("b2b t8 ar_valid", 32'(bus.m_ar_valid_o), 32'd0);
        chk("b2b t8 r_valid", 32'(bus.slv_r_valid_o), 32'd0);
        step();

        // Reset asserted while waiting for B.
        bus.slv_we_i     = 1'b1;
        bus.slv_addr_i   = 32'h6000_0010;
        bus.slv_wdata_i  = 32'h7654_3210;
        bus.slv_be_i     = 4'hF;
        bus.slv_req_i    = 1'b1;
        bus.m_aw_ready_i = 1'b1;
        bus.m_w_ready_i  = 1'b1;
        step();
        chk("rstw t1 aw_valid", 32'(bus.m_aw_valid_o), 32'd1);
        step();
        chk("rstw t2 gnt", 32'(bus.slv_gnt_o), 32'd1);
        idle_inputs();
        step();
        chk("rstw t3 b_ready", 32'(bus.m_b_ready_o), 32'd1);
        rst = 1'b1;
        #1;
        chk_all_idle("mid_reset");
        #2 rst = 1'b0;
        step();
        post = '{1'b0, 32'h0000_0100, 32'h0, 4'hF, 0, 0, 1, 32'h7777_8888, 2'b00, 2, 4, 32'h7777_8888, 1'b0};
        do_txn(post, "post_reset_read");
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
